hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline sequencing controller for the 5-stage CPU. Generates PC/IF_ID write enables, IF_ID/ID_EX flushes
//   and an EX hold from: load-use hazards (ID vs EX), taken branches resolved in EX, jumps decoded in ID,
//   and multi-cycle EX ops (mult/div). Forwarding handles all other RAW hazards; this block covers the rest.
// PARAMETERS
//   MC_CYCLES  32  total EX cycles a multi-cycle op occupies; legal range 2..2**CNT_W-1
//   CNT_W      6   width of the multi-cycle down-counter
// PORTS
//   clk               in   1   clock, rising edge
//   rst_n             in   1   asynchronous reset, active low
//   ID_Rs             in   5   rs field of instruction in ID
//   ID_Rt             in   5   rt field of instruction in ID
//   ID_UseRt          in   1   instruction in ID reads rt as a source
//   ID_Jump           in   1   jump (j/jal/jr/jalr) decoded in ID
//   EX_MemRead        in   1   instruction in EX is a load
//   EX_WriteRegister  in   5   destination register of instruction in EX
//   EX_MultiCycle     in   1   instruction in EX is mult/div; held high while it remains in EX
//   EX_BranchTaken    in   1   branch in EX resolved taken
//   PC_Write          out  1   PC register load enable
//   IF_ID_Write       out  1   IF_ID register load enable
//   IF_ID_Flush       out  1   replace IF_ID contents with NOP
//   ID_EX_Flush       out  1   replace ID_EX contents with bubble
//   EX_Hold           out  1   hold ID_EX and block the EX_MEM write (a bubble is written to EX_MEM)
//   MC_Done           out  1   one-cycle pulse: multi-cycle result is valid this cycle
//   Busy              out  1   FSM is in MC_BUSY
//   StallCount        out  32  cycles with PC_Write=0 since reset; wraps at 2**32
// BEHAVIOUR
//   Reset, asynchronous: state=RUN, cnt=0, StallCount=0.
//   Outputs while rst_n=0: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, EX_Hold=0, MC_Done=0, Busy=0.
//   All control outputs are combinational from state, cnt and inputs (same-cycle stall). State, cnt and
//     StallCount are registered.
//   Default (no event): PC_Write=1, IF_ID_Write=1, all flush/hold/done outputs 0.
//   LoadUse = EX_MemRead && EX_WriteRegister!=0 &&
//     (EX_WriteRegister==ID_Rs || (ID_UseRt && EX_WriteRegister==ID_Rt)).
//   State RUN, events in priority order (first match wins):
//     1 EX_BranchTaken: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1. ID_Jump and LoadUse are ignored.
//     2 EX_MultiCycle: PC_Write=0, IF_ID_Write=0, EX_Hold=1; cnt<=MC_CYCLES-1; next state MC_BUSY.
//     3 LoadUse: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 (exactly one bubble). A jump in ID waits for the
//       next cycle (jr may depend on the load).
//     4 ID_Jump: IF_ID_Flush=1, PC_Write=1.
//   State MC_BUSY: Busy=1; ID_Jump, LoadUse and EX_MultiCycle are ignored.
//     cnt>1: PC_Write=0, IF_ID_Write=0, EX_Hold=1, cnt<=cnt-1.
//     cnt==1: MC_Done=1, EX_Hold=0, pipeline advances (PC_Write=1, IF_ID_Write=1); next state RUN, cnt<=0.
//   Latency: a multi-cycle op occupies EX for exactly MC_CYCLES cycles, of which MC_CYCLES-1 are stalls.
//   EX_BranchTaken and EX_MultiCycle are mutually exclusive. A bench assertion flags simultaneous assertion;
//     the RTL applies priority 1.
//   StallCount increments on each cycle with rst_n=1 and PC_Write=0; 32'hFFFFFFFF wraps to 0.
//   Reset during MC_BUSY: immediate return to RUN. No MC_Done pulse is produced.
// TESTING
//   1 EX lw $t0 (MemRead=1, WR=8), ID add using ID_Rs=8 -> one cycle PC_Write=0, IF_ID_Write=0,
//     ID_EX_Flush=1; next cycle defaults; StallCount=1.
//   2 Load to $0 (WR=0, ID_Rs=0) -> no stall. ID_UseRt=0 with ID_Rt==WR -> no stall.
//   3 EX_MultiCycle=1, MC_CYCLES=32 -> EX_Hold=1 for 31 cycles, then MC_Done=1 for one cycle with
//     PC_Write=1; Busy high for 31 cycles; StallCount=31.
//   4 EX_BranchTaken=1 with ID_Jump=1 and LoadUse=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1 only.
//   5 LoadUse and ID_Jump together -> stall cycle without IF_ID_Flush; next cycle IF_ID_Flush=1, PC_Write=1.
//   6 rst_n low at cnt=10 in MC_BUSY -> Busy=0 immediately, no MC_Done; after release defaults,
//     StallCount=0; preload StallCount=32'hFFFFFFFF then one stall -> 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencing controller for a 5-stage CPU. Generates the PC and
//   IF_ID write enables, the IF_ID and ID_EX flushes, and an EX hold. It covers
//   the cases that forwarding cannot resolve:
//     - load-use hazards (load in EX feeding the instruction in ID)
//     - taken branches resolved in EX
//     - jumps decoded in ID
//     - multi-cycle EX operations (mult/div)
//   The control outputs are combinational, so a stall takes effect in the same
//   cycle as the event that causes it. Only the FSM state, the multi-cycle
//   down-counter and the stall statistic are registered.
//
// Parameters
//   MC_CYCLES  total EX cycles a multi-cycle op occupies (2 .. 2**CNT_W-1)
//   CNT_W      width of the multi-cycle down-counter
//
// Ports
//   clk               in   1   clock, rising edge
//   rst_n             in   1   asynchronous reset, active low
//   ID_Rs             in   5   rs field of the instruction in ID
//   ID_Rt             in   5   rt field of the instruction in ID
//   ID_UseRt          in   1   instruction in ID reads rt as a source
//   ID_Jump           in   1   jump (j/jal/jr/jalr) decoded in ID
//   EX_MemRead        in   1   instruction in EX is a load
//   EX_WriteRegister  in   5   destination register of the instruction in EX
//   EX_MultiCycle     in   1   instruction in EX is mult/div (held while in EX)
//   EX_BranchTaken    in   1   branch in EX resolved taken
//   PC_Write          out  1   PC register load enable
//   IF_ID_Write       out  1   IF_ID register load enable
//   IF_ID_Flush       out  1   replace IF_ID contents with a NOP
//   ID_EX_Flush       out  1   replace ID_EX contents with a bubble
//   EX_Hold           out  1   hold ID_EX, write a bubble into EX_MEM
//   MC_Done           out  1   one-cycle pulse: multi-cycle result valid
//   Busy              out  1   a multi-cycle op is draining (MC_BUSY)
//   StallCount        out  32  cycles with PC_Write=0 since reset (wraps)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MC_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UseRt,
  input  logic        ID_Jump,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_WriteRegister,
  input  logic        EX_MultiCycle,
  input  logic        EX_BranchTaken,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_Hold,
  output logic        MC_Done,
  output logic        Busy,
  output logic [31:0] StallCount
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } state_t;

  // The first EX cycle of a multi-cycle op is spent in RUN, so the counter
  // is loaded with the number of cycles that remain after it.
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_stall_count;
  logic             w_load_use;
  logic             w_stall;

  // Writes to $0 are discarded, so a load to $0 can never create a hazard.
  // rt only matters when the ID instruction actually reads it.
  assign w_load_use = EX_MemRead && (EX_WriteRegister != 5'd0) &&
                      ((EX_WriteRegister == ID_Rs) ||
                       (ID_UseRt && (EX_WriteRegister == ID_Rt)));

  // NOTE: every signal written here receives a default before any branch,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    EX_Hold     = 1'b0;
    MC_Done     = 1'b0;
    Busy        = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;

    if (!rst_n) begin
      // Keep the front of the pipeline frozen and flushed while in reset.
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (EX_BranchTaken) begin
            // Both younger instructions are on the wrong path; a jump or a
            // load-use stall in ID is moot because ID is being squashed.
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (EX_MultiCycle) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            EX_Hold     = 1'b1;
            w_cnt_nxt   = MC_LOAD;
            w_state_nxt = ST_MC_BUSY;
          end else if (w_load_use) begin
            // One bubble into EX; the jump (possibly a jr on the loaded
            // register) is taken on the following cycle once the data is
            // forwardable.
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end else if (ID_Jump) begin
            IF_ID_Flush = 1'b1;
          end
        end

        ST_MC_BUSY: begin
          Busy = 1'b1;
          if (r_cnt > CNT_ONE) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            EX_Hold     = 1'b1;
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end else begin
            // Last EX cycle: result is valid and the pipeline advances.
            MC_Done     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RUN;
          end
        end

        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // During reset PC_Write is low, but those cycles are not counted.
  assign w_stall = rst_n && !PC_Write;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the update order is irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Free-running statistic; natural 32-bit overflow provides the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign StallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. The driver applies one input vector
//   per cycle shortly after the rising edge and pushes the hand-computed
//   expected outputs into a queue; the monitor pops and compares on the
//   falling edge. StallCount expectations come from a running count of the
//   cycles the vectors mark as stalls.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       jump;
    logic       memread;
    logic [4:0] wr;
    logic       mc;
    logic       br;
  } in_t;

  // ctl bit order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
  //                 EX_Hold, MC_Done, Busy}
  typedef struct packed {
    logic [6:0]  ctl;
    logic [31:0] stall;
  } out_t;

  localparam logic [6:0] C_DEF  = 7'b1100000;
  localparam logic [6:0] C_RST  = 7'b0011000;
  localparam logic [6:0] C_LU   = 7'b0001000;
  localparam logic [6:0] C_BR   = 7'b1111000;
  localparam logic [6:0] C_JMP  = 7'b1110000;
  localparam logic [6:0] C_MCS  = 7'b0000100;
  localparam logic [6:0] C_MCB  = 7'b0000101;
  localparam logic [6:0] C_MCD  = 7'b1100011;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UseRt;
  logic        ID_Jump;
  logic        EX_MemRead;
  logic [4:0]  EX_WriteRegister;
  logic        EX_MultiCycle;
  logic        EX_BranchTaken;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        EX_Hold;
  logic        MC_Done;
  logic        Busy;
  logic [31:0] StallCount;

  hazard_ctrl #(.MC_CYCLES(32), .CNT_W(6)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ID_Rs            (ID_Rs),
    .ID_Rt            (ID_Rt),
    .ID_UseRt         (ID_UseRt),
    .ID_Jump          (ID_Jump),
    .EX_MemRead       (EX_MemRead),
    .EX_WriteRegister (EX_WriteRegister),
    .EX_MultiCycle    (EX_MultiCycle),
    .EX_BranchTaken   (EX_BranchTaken),
    .PC_Write         (PC_Write),
    .IF_ID_Write      (IF_ID_Write),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Flush      (ID_EX_Flush),
    .EX_Hold          (EX_Hold),
    .MC_Done          (MC_Done),
    .Busy             (Busy),
    .StallCount       (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t        exp_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_stall = '0;

  localparam in_t IDLE = '0;

  function automatic in_t mk_in(input logic [4:0] rs, input logic [4:0] rt,
                                input logic use_rt, input logic jump,
                                input logic memread, input logic [4:0] wr,
                                input logic mc, input logic br);
    in_t v;
    v.rs = rs; v.rt = rt; v.use_rt = use_rt; v.jump = jump;
    v.memread = memread; v.wr = wr; v.mc = mc; v.br = br;
    return v;
  endfunction

  // One clock cycle of stimulus plus its expected response.
  task automatic cycle(input logic rst_val, input in_t v,
                       input logic [6:0] ctl, input string name);
    out_t e;
    @(posedge clk);
    #1;
    rst_n            = rst_val;
    ID_Rs            = v.rs;
    ID_Rt            = v.rt;
    ID_UseRt         = v.use_rt;
    ID_Jump          = v.jump;
    EX_MemRead       = v.memread;
    EX_WriteRegister = v.wr;
    EX_MultiCycle    = v.mc;
    EX_BranchTaken   = v.br;
    if (!rst_val) exp_stall = '0;
    e.ctl   = ctl;
    e.stall = exp_stall;
    exp_q.push_back(e);
    name_q.push_back(name);
    if (rst_val && !ctl[6]) exp_stall = exp_stall + 32'd1;
  endtask

  // Monitor: compares whenever an expectation is pending.
  initial begin
    out_t  got;
    out_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got.ctl   = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
                     EX_Hold, MC_Done, Busy};
        got.stall = StallCount;
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL %s: got ctl=%b stall=%h, expected ctl=%b stall=%h",
                   nm, got.ctl, got.stall, e.ctl, e.stall);
        end
      end
    end
  end

  // Branch and multi-cycle must never be presented together.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(EX_BranchTaken && EX_MultiCycle))
        else $error("illegal stimulus: EX_BranchTaken and EX_MultiCycle both high");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ID_Rs = '0; ID_Rt = '0; ID_UseRt = 1'b0; ID_Jump = 1'b0;
    EX_MemRead = 1'b0; EX_WriteRegister = '0;
    EX_MultiCycle = 1'b0; EX_BranchTaken = 1'b0;

    // Reset state and release.
    cycle(1'b0, IDLE, C_RST, "reset_0");
    cycle(1'b0, IDLE, C_RST, "reset_1");
    cycle(1'b1, IDLE, C_DEF, "post_reset_default");

    // 1: lw $t0 in EX, add using $t0 as rs in ID.
    cycle(1'b1, mk_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0), C_LU, "loaduse_rs");
    cycle(1'b1, IDLE, C_DEF, "loaduse_rs_after");

    // 2: no stall for $0 destination or for an unused rt match.
    cycle(1'b1, mk_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0), C_DEF, "load_to_zero");
    cycle(1'b1, mk_in(5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0), C_DEF, "rt_unused");
    cycle(1'b1, mk_in(5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0), C_LU, "loaduse_rt");
    cycle(1'b1, mk_in(5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0), C_DEF, "no_memread");

    // 4: taken branch outranks jump and load-use.
    cycle(1'b1, mk_in(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1), C_BR, "branch_priority");
    cycle(1'b1, mk_in(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1), C_BR, "branch_alone");

    // 5: load-use with a jump stalls first, then the jump proceeds.
    cycle(1'b1, mk_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0), C_LU, "loaduse_jump_stall");
    cycle(1'b1, mk_in(5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0), C_JMP, "jump_after_stall");
    cycle(1'b1, IDLE, C_DEF, "idle_a");

    // 3: full multi-cycle op; jump and load-use in ID are ignored while busy.
    cycle(1'b1, mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), C_MCS, "mc_start");
    for (int i = 0; i < 30; i++) begin
      if (i == 3)
        cycle(1'b1, mk_in(5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0), C_MCB,
              $sformatf("mc_busy_%0d_ignore", i));
      else
        cycle(1'b1, mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), C_MCB,
              $sformatf("mc_busy_%0d", i));
    end
    cycle(1'b1, mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), C_MCD, "mc_done");
    cycle(1'b1, IDLE, C_DEF, "mc_after");

    // 6: reset in the middle of MC_BUSY (counter at 10).
    cycle(1'b1, mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), C_MCS, "mc2_start");
    for (int i = 0; i < 21; i++)
      cycle(1'b1, mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), C_MCB,
            $sformatf("mc2_busy_%0d", i));
    cycle(1'b0, mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0), C_RST, "mc2_reset_cnt10");
    cycle(1'b0, IDLE, C_RST, "mc2_reset_hold");
    cycle(1'b1, IDLE, C_DEF, "mc2_release");
    cycle(1'b1, IDLE, C_DEF, "mc2_idle");

    // StallCount wrap: preload all-ones between edges, then one stall.
    @(negedge clk);
    #1;
    force dut.r_stall_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_count;
    exp_stall = 32'hFFFF_FFFF;
    cycle(1'b1, mk_in(5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0), C_LU, "wrap_stall");
    cycle(1'b1, IDLE, C_DEF, "wrap_zero");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
